// File: rtl/bomb_controller.sv
`default_nettype none
// ============================================================================
//  Module   : bomb_controller
//  Purpose  : Frame-timed lifecycle of one bomb: place, fuse, explode, cooldown.
//  Revision : 1.0 - initial release
// ============================================================================

module bomb_controller #(
    parameter int FUSE_FRAMES     = 120,
    parameter int BLINK_FRAMES    = 30,
    parameter int EXPLODE_FRAMES  = 30,
    parameter int COOLDOWN_FRAMES = 15,
    parameter int TILE_BITS       = 5
) (
    input  logic        clk,
    input  logic        resetN,
    input  logic        startOfFrame,
    input  logic        place_req,
    input  logic [10:0] heroX,
    input  logic [10:0] heroY,
    input  logic        chain_hit,
    output logic        bomb_exist,
    output logic        bomb_exploded,
    output logic        sprite_sel,
    output logic [10:0] bombTopLeftX,
    output logic [10:0] bombTopLeftY,
    output logic        explode_pulse,
    output logic        ready
);

    localparam int                 c_CNT_W         = 16;
    localparam logic [c_CNT_W-1:0] c_FUSE_LOAD     = c_CNT_W'(FUSE_FRAMES - 1);
    localparam logic [c_CNT_W-1:0] c_EXPLODE_LOAD  = c_CNT_W'(EXPLODE_FRAMES - 1);
    localparam logic [c_CNT_W-1:0] c_COOLDOWN_LOAD = c_CNT_W'(COOLDOWN_FRAMES - 1);
    localparam logic [c_CNT_W-1:0] c_BLINK         = c_CNT_W'(BLINK_FRAMES);
    localparam logic [10:0]        c_HALF_TILE     = 11'(2 ** (TILE_BITS - 1));
    localparam logic [10:0]        c_TILE_MASK     = ~11'(2 ** TILE_BITS - 1);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_FUSE     = 2'd1,
        S_EXPLODE  = 2'd2,
        S_COOLDOWN = 2'd3
    } state_t;

    state_t             r_state;
    logic [c_CNT_W-1:0] r_cnt;

    state_t             w_state_next;
    logic [c_CNT_W-1:0] w_cnt_next;
    logic               w_cnt_zero;
    logic               w_accept;
    logic               w_fire;
    logic               w_blink;
    logic [10:0]        w_snap_x;
    logic [10:0]        w_snap_y;

    assign w_cnt_zero = (r_cnt == '0);
    assign w_accept   = (r_state == S_IDLE) && place_req;

    // Round to the nearest tile: add half a tile, then drop the in-tile bits.
    assign w_snap_x = (heroX + c_HALF_TILE) & c_TILE_MASK;
    assign w_snap_y = (heroY + c_HALF_TILE) & c_TILE_MASK;

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        unique case (r_state)
            S_IDLE: begin
                if (place_req) begin
                    w_state_next = S_FUSE;
                    w_cnt_next   = c_FUSE_LOAD;
                end
            end
            S_FUSE: begin
                if (chain_hit || (startOfFrame && w_cnt_zero)) begin
                    w_state_next = S_EXPLODE;
                    w_cnt_next   = c_EXPLODE_LOAD;
                end else if (startOfFrame) begin
                    w_cnt_next = r_cnt - 1'b1;
                end
            end
            S_EXPLODE: begin
                if (startOfFrame && w_cnt_zero) begin
                    w_state_next = S_COOLDOWN;
                    w_cnt_next   = c_COOLDOWN_LOAD;
                end else if (startOfFrame) begin
                    w_cnt_next = r_cnt - 1'b1;
                end
            end
            S_COOLDOWN: begin
                if (startOfFrame && w_cnt_zero) begin
                    w_state_next = S_IDLE;
                    w_cnt_next   = '0;
                end else if (startOfFrame) begin
                    w_cnt_next = r_cnt - 1'b1;
                end
            end
            default: begin
                w_state_next = S_IDLE;
                w_cnt_next   = '0;
            end
        endcase
    end

    // Outputs are registered from the next state so they line up with r_state.
    assign w_fire  = (r_state == S_FUSE) && (w_state_next == S_EXPLODE);
    assign w_blink = (w_cnt_next < c_BLINK) && w_cnt_next[2];

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_state       <= S_IDLE;
            r_cnt         <= '0;
            bomb_exist    <= 1'b0;
            bomb_exploded <= 1'b0;
            sprite_sel    <= 1'b0;
            bombTopLeftX  <= '0;
            bombTopLeftY  <= '0;
            explode_pulse <= 1'b0;
            ready         <= 1'b1;
        end else begin
            r_state       <= w_state_next;
            r_cnt         <= w_cnt_next;
            bomb_exist    <= (w_state_next == S_FUSE) || (w_state_next == S_EXPLODE);
            bomb_exploded <= (w_state_next == S_EXPLODE);
            sprite_sel    <= (w_state_next == S_EXPLODE) ||
                             ((w_state_next == S_FUSE) && w_blink);
            explode_pulse <= w_fire;
            ready         <= (w_state_next == S_IDLE);
            if (w_accept) begin
                bombTopLeftX <= w_snap_x;
                bombTopLeftY <= w_snap_y;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_bomb_controller.sv
`default_nettype none
// ============================================================================
//  Module   : tb_bomb_controller
//  Purpose  : Directed and random stimulus against a frame-count reference model.
//  Revision : 1.0 - initial release
// ============================================================================

module tb_bomb_controller;

    localparam int FUSE     = 4;
    localparam int BLINK    = 2;
    localparam int EXPLODE  = 2;
    localparam int COOLDOWN = 1;
    localparam int TILE     = 5;

    logic        clk = 1'b0;
    logic        resetN = 1'b0;
    logic        startOfFrame = 1'b0;
    logic        place_req = 1'b0;
    logic [10:0] heroX = '0;
    logic [10:0] heroY = '0;
    logic        chain_hit = 1'b0;
    logic        bomb_exist;
    logic        bomb_exploded;
    logic        sprite_sel;
    logic [10:0] bombTopLeftX;
    logic [10:0] bombTopLeftY;
    logic        explode_pulse;
    logic        ready;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: phase plus number of frame ticks still to elapse in it.
    int m_phase;   // 0 idle, 1 fuse, 2 explode, 3 cooldown
    int m_left;
    int m_x, m_y;
    int m_pulse;

    bomb_controller #(
        .FUSE_FRAMES    (FUSE),
        .BLINK_FRAMES   (BLINK),
        .EXPLODE_FRAMES (EXPLODE),
        .COOLDOWN_FRAMES(COOLDOWN),
        .TILE_BITS      (TILE)
    ) u_dut (
        .clk          (clk),
        .resetN       (resetN),
        .startOfFrame (startOfFrame),
        .place_req    (place_req),
        .heroX        (heroX),
        .heroY        (heroY),
        .chain_hit    (chain_hit),
        .bomb_exist   (bomb_exist),
        .bomb_exploded(bomb_exploded),
        .sprite_sel   (sprite_sel),
        .bombTopLeftX (bombTopLeftX),
        .bombTopLeftY (bombTopLeftY),
        .explode_pulse(explode_pulse),
        .ready        (ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int snap(input int v);
        return ((v + (1 << (TILE - 1))) % 2048) / (1 << TILE) * (1 << TILE);
    endfunction

    task automatic model_reset();
        m_phase = 0; m_left = 0; m_x = 0; m_y = 0; m_pulse = 0;
    endtask

    task automatic model_step(input bit p, input bit s, input bit c, input int x, input int y);
        m_pulse = 0;
        case (m_phase)
            0: if (p) begin
                m_phase = 1; m_left = FUSE; m_x = snap(x); m_y = snap(y);
            end
            1: begin
                if (s) m_left--;
                if (c || m_left == 0) begin
                    m_phase = 2; m_left = EXPLODE; m_pulse = 1;
                end
            end
            2: if (s) begin
                m_left--;
                if (m_left == 0) begin m_phase = 3; m_left = COOLDOWN; end
            end
            default: if (s) begin
                m_left--;
                if (m_left == 0) m_phase = 0;
            end
        endcase
    endtask

    task automatic compare_all();
        int ctr;
        bit exp_spr;
        ctr = m_left - 1;
        exp_spr = (m_phase == 2) || (m_phase == 1 && ctr < BLINK && ((ctr >> 2) & 1) == 1);
        check("bomb_exist",    32'(bomb_exist),    32'(m_phase == 1 || m_phase == 2));
        check("bomb_exploded", 32'(bomb_exploded), 32'(m_phase == 2));
        check("sprite_sel",    32'(sprite_sel),    32'(exp_spr));
        check("explode_pulse", 32'(explode_pulse), 32'(m_pulse));
        check("ready",         32'(ready),         32'(m_phase == 0));
        check("topleft_x",     32'(bombTopLeftX),  32'(m_x));
        check("topleft_y",     32'(bombTopLeftY),  32'(m_y));
    endtask

    // Inputs are driven at the negedge, the model advances at the posedge,
    // and outputs are compared at the following negedge.
    task automatic cyc(input bit p, input bit s, input bit c, input int x, input int y);
        place_req = p; startOfFrame = s; chain_hit = c;
        heroX = 11'(x); heroY = 11'(y);
        @(posedge clk);
        model_step(p, s, c, x, y);
        @(negedge clk);
        compare_all();
    endtask

    task automatic async_reset();
        #2 resetN = 1'b0;
        #1;
        check("rst_exist_async", 32'(bomb_exist), 32'd0);
        check("rst_ready_async", 32'(ready), 32'd1);
        model_reset();
        @(negedge clk);
        compare_all();
        resetN = 1'b1;
    endtask

    initial begin
        model_reset();
        @(negedge clk);
        compare_all();
        resetN = 1'b1;
        cyc(0, 0, 0, 0, 0);

        // Basic placement and full lifecycle with snapping.
        cyc(1, 0, 0, 45, 70);
        check("snap_x_45", 32'(bombTopLeftX), 32'd32);
        check("snap_y_70", 32'(bombTopLeftY), 32'd64);
        for (int i = 0; i < 4; i++) begin
            cyc(0, 0, 0, 0, 0);
            cyc(0, 1, 0, 0, 0);
        end
        check("pulse_after_4sof", 32'(explode_pulse), 32'd1);
        cyc(0, 0, 0, 0, 0);
        check("pulse_one_clk", 32'(explode_pulse), 32'd0);
        for (int i = 0; i < 2; i++) cyc(0, 1, 0, 0, 0);
        check("exist_gone", 32'(bomb_exist), 32'd0);
        cyc(0, 1, 0, 0, 0);
        check("ready_back", 32'(ready), 32'd1);

        // Placement coinciding with a frame tick; chain_hit on the expiry tick.
        cyc(1, 1, 0, 1000, 2040);
        for (int i = 0; i < 3; i++) cyc(0, 1, 0, 0, 0);
        check("no_early_explode", 32'(bomb_exploded), 32'd0);
        cyc(0, 1, 1, 0, 0);
        check("single_pulse_sim", 32'(explode_pulse), 32'd1);
        for (int i = 0; i < 4; i++) cyc(0, 1, 1, 0, 0);

        // Early chain detonation, repeated chain in explode.
        cyc(1, 0, 0, 15, 16);
        cyc(0, 1, 0, 0, 0);
        cyc(0, 0, 1, 0, 0);
        check("chain_explode", 32'(explode_pulse), 32'd1);
        cyc(0, 0, 1, 0, 0);
        check("chain_no_repulse", 32'(explode_pulse), 32'd0);
        for (int i = 0; i < 4; i++) cyc(0, 1, 0, 0, 0);

        // place_req held through the whole lifecycle.
        for (int i = 0; i < 30; i++) cyc(1, (i % 2) == 1, 0, 100 + i * 7, 300 + i * 3);

        // Reset in the middle of a fuse.
        cyc(1, 0, 0, 500, 600);
        cyc(0, 1, 0, 0, 0);
        async_reset();
        cyc(0, 0, 0, 0, 0);

        // Random traffic.
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 599) == 0) async_reset();
            else cyc($urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0,
                     $urandom_range(0, 9) == 0, int'($urandom_range(0, 2047)),
                     int'($urandom_range(0, 2047)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
